// File: rtl/pi_noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pi_noc_pkg
// Description : Shared pi-NoC definitions: width helper functions, router
//               port-select constants and the default-width flit record.
// Revision    : 1.0 - initial release
// ============================================================================
package pi_noc_pkg;

    // Flit address width for an N-client tree: client index plus one bit.
    function automatic int pi_a_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Index width for K requesters; at least one bit so a 1-wide port exists.
    function automatic int pi_src_w(input int k);
        return (k < 2) ? 1 : $clog2(k);
    endfunction

    // Router port selects, shared with the pi router switch logic.
    localparam logic [1:0] LEFT  = 2'd0;
    localparam logic [1:0] RIGHT = 2'd1;
    localparam logic [1:0] U0    = 2'd2;
    localparam logic [1:0] U1    = 2'd3;

    // Default network geometry used by the flit record below.
    localparam int PI_DEF_N   = 8;
    localparam int PI_DEF_D_W = 32;
    localparam int PI_DEF_A_W = $clog2(PI_DEF_N) + 1;

    // One flit as carried on a router link.
    typedef struct packed {
        logic [PI_DEF_A_W-1:0] addr;
        logic [PI_DEF_D_W-1:0] data;
    } pi_flit_t;

endpackage
`default_nettype wire

// File: rtl/pi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : pi_rr_pick
// Description : Combinational rotating-priority picker. Returns the first
//               set request found scanning base, base+1, ... modulo K.
// Revision    : 1.0 - initial release
// ============================================================================
module pi_rr_pick #(
    parameter int K     = 4,
    parameter int SRC_W = 2
) (
    input  logic [K-1:0]     req,
    input  logic [SRC_W-1:0] base,
    output logic [SRC_W-1:0] idx,
    output logic             any
);

    // Scan from the farthest offset back to the base so the nearest hit wins.
    always_comb begin
        logic [SRC_W-1:0] j;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int off = K - 1; off >= 0; off--) begin
            // Explicit modulo keeps non-power-of-two K wrapping correctly.
            j = SRC_W'((int'(base) + off) % K);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pi_inject_arb.sv
`default_nettype none
// ============================================================================
// Module      : pi_inject_arb
// Description : Shares one leaf injection port between K local requesters.
//               Round-robin pick with a starvation override, winner is
//               registered into a one-entry output stage toward the router.
// Revision    : 1.0 - initial release
// ============================================================================
module pi_inject_arb
    import pi_noc_pkg::*;
#(
    parameter int N      = 8,
    parameter int A_W    = pi_a_w(N),
    parameter int D_W    = 32,
    parameter int K      = 4,
    parameter int SRC_W  = pi_src_w(K),
    parameter int STARVE = 15,
    parameter int CNT_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [K-1:0]       s_v,
    output logic [K-1:0]       s_bp,
    input  logic [K*A_W-1:0]   s_addr,
    input  logic [K*D_W-1:0]   s_data,
    output logic               o_v,
    input  logic               o_bp,
    output logic [A_W-1:0]     o_addr,
    output logic [D_W-1:0]     o_data,
    output logic [SRC_W-1:0]   grant_id,
    output logic               starve
);

    localparam logic [SRC_W-1:0] c_BASE0   = '0;
    localparam logic [SRC_W-1:0] c_LAST    = SRC_W'(K - 1);
    localparam logic [CNT_W-1:0] c_STARVE  = CNT_W'(STARVE);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [SRC_W-1:0] r_rr;
    logic [CNT_W-1:0] r_cnt [K];

    logic [K-1:0]     w_starved;
    logic [SRC_W-1:0] w_rr_idx;
    logic             w_rr_any;
    logic [SRC_W-1:0] w_ovr_idx;
    logic             w_ovr;
    logic [SRC_W-1:0] w_g;
    logic             w_load;
    logic             w_take;

    // A requester is starved once it has waited STARVE cycles while valid.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            w_starved[i] = s_v[i] & (r_cnt[i] >= c_STARVE);
        end
    end

    // Normal fair pick rotating from the round-robin pointer.
    pi_rr_pick #(
        .K     (K),
        .SRC_W (SRC_W)
    ) u_pick_rr (
        .req  (s_v),
        .base (r_rr),
        .idx  (w_rr_idx),
        .any  (w_rr_any)
    );

    // Override pick: fixed base 0 so the lowest starved index wins.
    pi_rr_pick #(
        .K     (K),
        .SRC_W (SRC_W)
    ) u_pick_ovr (
        .req  (w_starved),
        .base (c_BASE0),
        .idx  (w_ovr_idx),
        .any  (w_ovr)
    );

    // Winner selection and load condition (register empty or draining).
    always_comb begin
        w_g    = w_ovr ? w_ovr_idx : w_rr_idx;
        w_load = ce & (~o_v | ~o_bp);
        w_take = w_load & w_rr_any;
    end

    // Only the granted requester sees its backpressure released.
    generate
        for (genvar i = 0; i < K; i++) begin : g_bp
            assign s_bp[i] = s_v[i] & ~(w_take & (w_g == SRC_W'(i)));
        end
    endgenerate

    // Output stage and round-robin pointer; held on stall or ce=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_v      <= 1'b0;
            o_addr   <= '0;
            o_data   <= '0;
            grant_id <= '0;
            starve   <= 1'b0;
            r_rr     <= '0;
        end else if (w_take) begin
            o_v      <= 1'b1;
            o_addr   <= s_addr[int'(w_g)*A_W +: A_W];
            o_data   <= s_data[int'(w_g)*D_W +: D_W];
            grant_id <= w_g;
            starve   <= w_ovr;
            r_rr     <= (w_g == c_LAST) ? '0 : w_g + 1'b1;
        end else if (w_load) begin
            o_v      <= 1'b0;
        end
    end

    // Per-requester saturating wait counters, cleared on idle or transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (ce) begin
            for (int i = 0; i < K; i++) begin
                if (!s_v[i] || (w_take && (w_g == SRC_W'(i)))) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != c_CNT_MAX) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pi_inject_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_pi_inject_arb
// Description : Randomized self-checking bench for pi_inject_arb against a
//               cycle-level behavioural model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_inject_arb;

    localparam int N      = 8;
    localparam int K      = 4;
    localparam int A_W    = 4;
    localparam int D_W    = 32;
    localparam int SRC_W  = 2;
    localparam int STARVE = 3;
    localparam int CNT_W  = 4;
    localparam int CMAX   = 15;

    logic               clk = 1'b0;
    logic               rst;
    logic               ce;
    logic [K-1:0]       s_v;
    logic [K-1:0]       s_bp;
    logic [K*A_W-1:0]   s_addr;
    logic [K*D_W-1:0]   s_data;
    logic               o_v;
    logic               o_bp;
    logic [A_W-1:0]     o_addr;
    logic [D_W-1:0]     o_data;
    logic [SRC_W-1:0]   grant_id;
    logic               starve;

    always #5 clk = ~clk;

    pi_inject_arb #(
        .N      (N),
        .A_W    (A_W),
        .D_W    (D_W),
        .K      (K),
        .SRC_W  (SRC_W),
        .STARVE (STARVE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .s_v      (s_v),
        .s_bp     (s_bp),
        .s_addr   (s_addr),
        .s_data   (s_data),
        .o_v      (o_v),
        .o_bp     (o_bp),
        .o_addr   (o_addr),
        .o_data   (o_data),
        .grant_id (grant_id),
        .starve   (starve)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int               m_cnt [K];
    int               m_rr;
    bit               m_v;
    logic [A_W-1:0]   m_addr;
    logic [D_W-1:0]   m_data;
    int               m_gid;
    bit               m_st;
    int               n_ovr;

    // Source state: pending flit per requester and whether it must be held
    bit               p_v    [K];
    logic [A_W-1:0]   p_addr [K];
    logic [D_W-1:0]   p_data [K];
    bit               p_hold [K];

    // Phase knobs (percentages)
    logic [K-1:0]     ph_mask;
    int               ph_pv, ph_pbp, ph_pce;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner by the rules: lowest starved valid index, else first valid from rr.
    function automatic void winner(input logic [K-1:0] v, output int g,
                                   output bit ovr, output bit any);
        g = 0; ovr = 1'b0; any = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (v[i] && m_cnt[i] >= STARVE && !ovr) begin
                g = i; ovr = 1'b1; any = 1'b1;
            end
        end
        if (!ovr) begin
            for (int k = 0; k < K; k++) begin
                if (v[(m_rr + k) % K] && !any) begin
                    g = (m_rr + k) % K; any = 1'b1;
                end
            end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < K; i++) m_cnt[i] = 0;
        m_rr = 0; m_v = 1'b0; m_addr = '0; m_data = '0; m_gid = 0; m_st = 1'b0;
    endtask

    task automatic set_phase(input logic [K-1:0] mask, input int pv, input int pbp, input int pce);
        ph_mask = mask; ph_pv = pv; ph_pbp = pbp; ph_pce = pce;
    endtask

    // One clock cycle: drive at negedge, check, then advance model at posedge.
    task automatic step(input bit r, input bit do_chk);
        logic [K-1:0] ebp;
        int g;
        bit ovr, any, load;
        @(negedge clk);
        rst  = r;
        ce   = ($urandom_range(99) < ph_pce);
        o_bp = ($urandom_range(99) < ph_pbp);
        for (int i = 0; i < K; i++) begin
            if (!p_hold[i]) begin
                p_v[i]    = ph_mask[i] && ($urandom_range(99) < ph_pv);
                p_addr[i] = A_W'($urandom);
                p_data[i] = $urandom;
            end
            s_v[i]                = p_v[i];
            s_addr[i*A_W +: A_W]  = p_addr[i];
            s_data[i*D_W +: D_W]  = p_data[i];
        end
        #1;
        winner(s_v, g, ovr, any);
        load = ce && (!m_v || !o_bp);
        for (int i = 0; i < K; i++) ebp[i] = s_v[i] && !(load && any && g == i);
        if (do_chk) begin
            chk("s_bp",     64'(s_bp),     64'(ebp));
            chk("o_v",      64'(o_v),      64'(m_v));
            chk("o_addr",   64'(o_addr),   64'(m_addr));
            chk("o_data",   64'(o_data),   64'(m_data));
            chk("grant_id", 64'(grant_id), 64'(m_gid));
            chk("starve",   64'(starve),   64'(m_st));
        end
        for (int i = 0; i < K; i++) p_hold[i] = s_v[i] && ebp[i];
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (ce) begin
            for (int i = 0; i < K; i++) begin
                if (!s_v[i] || (load && any && g == i)) m_cnt[i] = 0;
                else if (m_cnt[i] < CMAX)                m_cnt[i] = m_cnt[i] + 1;
            end
            if (load && any) begin
                m_v = 1'b1; m_addr = p_addr[g]; m_data = p_data[g];
                m_gid = g; m_st = ovr; m_rr = (g + 1) % K;
                if (ovr) n_ovr++;
            end else if (load) begin
                m_v = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; o_bp = 1'b0;
        s_v = '0; s_addr = '0; s_data = '0;
        n_ovr = 0;
        for (int i = 0; i < K; i++) begin
            p_v[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0; p_hold[i] = 1'b0;
        end
        model_reset();
        set_phase(4'b0000, 0, 0, 100);

        // Reset, then check the reset state on the following cycle.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Single source only (requester 2).
        set_phase(4'b0100, 100, 0, 100);
        repeat (4) step(1'b0, 1'b1);

        // Full contention, no backpressure: strict rotation.
        set_phase(4'b1111, 100, 0, 100);
        repeat (12) step(1'b0, 1'b1);

        // Output stall with two requesters, then release.
        set_phase(4'b0011, 100, 100, 100);
        repeat (6) step(1'b0, 1'b1);
        set_phase(4'b0011, 100, 0, 100);
        repeat (4) step(1'b0, 1'b1);

        // Heavy backpressure with all requesters: forces starvation overrides.
        set_phase(4'b1111, 100, 60, 100);
        repeat (40) step(1'b0, 1'b1);

        // Clock-enable gating with everyone requesting.
        set_phase(4'b1111, 100, 0, 0);
        repeat (4) step(1'b0, 1'b1);
        set_phase(4'b1111, 100, 0, 100);
        repeat (4) step(1'b0, 1'b1);

        // Reset in the middle of a stall, then resume.
        set_phase(4'b1111, 100, 100, 100);
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        set_phase(4'b1111, 100, 0, 100);
        repeat (4) step(1'b0, 1'b1);

        // Long randomized run with shifting traffic profiles.
        for (int blk = 0; blk < 10; blk++) begin
            set_phase(K'($urandom), $urandom_range(100, 20), $urandom_range(80, 0),
                      $urandom_range(100, 60));
            for (int c = 0; c < 50; c++) begin
                step(($urandom_range(99) == 0), 1'b1);
            end
        end

        // The override path must actually have been exercised.
        chk("ovr_seen", 64'(n_ovr > 0), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pi_inject_arb.md
Name: pi_inject_arb

Overview:
- Injection scheduler that shares one leaf-level NoC injection port between K local requesters, e.g. a core, a DMA engine and a debug port on one client.
- Picks one requester per cycle by round-robin, with a starvation-override priority.
- Registers the winning flit into a one-entry output stage that drives the pi router's leaf input.
- Uses the router's valid/backpressure handshake on both sides.

Parameters:
- N, 8, number of NoC clients.
- A_W, $clog2(N)+1, flit address width.
- D_W, 32, flit data width.
- K, 4, number of local requesters (K >= 2).
- SRC_W, $clog2(K), requester index width.
- STARVE, 15, wait-cycle threshold that triggers priority override (1 .. 2^CNT_W-1).
- CNT_W, 4, width of each wait counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  clock enable.
- s_v  in  K  requester valid, one bit per requester.
- s_bp  out  K  requester backpressure, one bit per requester.
- s_addr  in  K*A_W  requester destination addresses; requester i occupies slice [i*A_W +: A_W].
- s_data  in  K*D_W  requester payloads; slice [i*D_W +: D_W].
- o_v  out  1  valid toward router leaf input.
- o_bp  in  1  backpressure from router.
- o_addr  out  A_W  registered flit address.
- o_data  out  D_W  registered flit data.
- grant_id  out  SRC_W  index of the requester whose flit currently sits in the output register.
- starve  out  1  registered flag: the last load was a starvation override.

Behaviour:
- Transfer rule, both sides: a flit moves in a cycle where valid=1 and bp=0. Sources must hold valid/addr/data stable while bp=1.
- load = ce & (~o_v | ~o_bp), meaning the output register is empty or draining this cycle.
- Winner g is computed combinationally.
  - If any source has cnt[i] >= STARVE and s_v[i]=1, g is the lowest such index and ovr=1.
  - Otherwise g is the first i with s_v[i]=1, scanning rr, rr+1, ... mod K; ovr=0.
- s_bp[i] = s_v[i] & ~(load & any_v & g==i). s_bp[i]=0 whenever s_v[i]=0.
- On load & any_v: o_v<=1, o_addr/o_data<=source g slice, grant_id<=g, starve<=ovr, rr<=(g+1) mod K.
- On load & ~any_v: o_v<=0. o_addr, o_data, grant_id, starve and rr are held.
- o_v=1 & o_bp=1: output register, rr and grant_id all hold. This covers stall.
- Latency: 1 cycle from input transfer to o_v. Sustained throughput is 1 flit/cycle when o_bp=0.
- Wait counters, updated only when ce=1:
  - cnt[i] <= 0 if s_v[i]=0 or source i transfers.
  - Otherwise cnt[i] <= min(cnt[i]+1, 2^CNT_W-1), i.e. it saturates and never wraps.
- ce=0: no state changes at all, and s_bp = s_v.
- Wrap-around: rr=K-1 with a grant to K-1 gives rr=0. For non-power-of-2 K, the modulo is explicit.
- Simultaneous starvation: the lowest index wins. The others keep counting and win on later cycles.
- Reset, including mid-operation:
  - Next edge sets o_v=0, o_addr=0, o_data=0, grant_id=0, starve=0, rr=0, all cnt=0.
  - Any flit held in the output register is discarded.
  - s_bp is combinational and reflects the post-reset state.

Decomposition:
- Package pi_noc_pkg holds:
  - helper functions for A_W and SRC_W;
  - LEFT/RIGHT/U0/U1 select constants, shared with the router;
  - the flit struct {addr, data}.
- One natural sub-module: pi_rr_pick.
  - Combinational.
  - Inputs: K-bit request vector and base pointer.
  - Outputs: winner index and any flag.
  - Used twice here: with base rr for normal picks, and with base 0 on the starved-request vector for overrides.
  - Reusable by the router's future round-robin rework.

Test Plan:
- Single source: s_v=4'b0100, addr=5, data=0xA5, o_bp=0 -> one cycle later o_v=1, o_addr=5, o_data=0xA5, grant_id=2, rr=3, s_bp=0.
- Full contention: s_v=4'b1111 held, o_bp=0, rr=0 -> grant_id sequence 0,1,2,3,0; each s_bp[i] drops exactly one cycle in four.
- Output stall: o_v=1 and o_bp=1 for 5 cycles with s_v=4'b0011 -> o_data, grant_id and rr stable; s_bp=2'b11; first load after o_bp falls grants the rr-indicated source.
- Starvation override: STARVE=3, rr=1, s_v[0]=1 plus s_v[1..3]=1, force o_bp pattern so source 0 is backpressured 3 cycles -> next load grants 0 with starve=1, regardless of rr.
- ce gating: ce=0 for 4 cycles with s_v=4'b1111 -> no transfers, s_bp=4'b1111, cnt unchanged; resumes exactly where it was when ce=1.
- Reset mid-stall: o_v=1, o_bp=1, rst pulsed 1 cycle -> next cycle o_v=0, grant_id=0, rr=0, all cnt=0; first grant after reset goes to source 0 if s_v[0]=1.
